cmac_tx_arbiter: RTL and testbench
==================================

Name: cmac_tx_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single CMAC TX AXI-Stream (512-bit, cmac_tx_clk domain) between two requesters.
- Source 0 is ERNIC egress, taken after the clock-domain-crossing FIFO. Source 1 is a raw/test packet source.
- Sits between the egress FIFOs and the CMAC user TX interface.
- Provides a packet-boundary TX enable, per-packet length and tkeep checking, and a busy indication.

Parameters:
- DATA_W, 512, tdata width; KEEP_W = DATA_W/8.
- MAX_BEATS, 32, maximum legal beats per packet (range 2..255).

Ports:
- cmac_tx_clk  in  1  sole clock.
- cmac_rst  in  1  synchronous active-high reset.
- tx_enable  in  1  allows new grants; sampled only in IDLE.
- s0_axis_tdata  in  DATA_W  source 0 data. s0_axis_tkeep in KEEP_W; s0_axis_tvalid in 1; s0_axis_tlast in 1.
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata / tkeep / tvalid / tlast  in  same widths  source 1.
- s1_axis_tready  out  1  source 1 ready.
- m_axis_tdata  out  DATA_W  to CMAC. m_axis_tkeep out KEEP_W; m_axis_tvalid out 1; m_axis_tlast out 1.
- m_axis_tready  in  1  CMAC ready.
- grant  out  2  one-hot current owner; 00 when IDLE.
- busy  out  1  high in state BUSY.
- err_len  out  1  one-cycle pulse: packet exceeded MAX_BEATS.
- err_keep  out  1  one-cycle pulse: non-last beat with tkeep not all-ones.

Behaviour:
- Reset (cmac_rst=1 at a clock edge), all outputs:
  - grant=00, busy=0, m_axis_tvalid=0, s*_tready=0, err_*=0.
  - State goes to IDLE; rr_last=1, so source 0 wins the first tie.
- Reset mid-packet abandons the packet immediately. The remainder of that packet is not forwarded. No recovery framing is applied.
- States: IDLE, BUSY.
- IDLE → BUSY:
  - Condition: tx_enable=1 and at least one s*_axis_tvalid=1.
  - Winner is the sole requester. If both request, the winner is the source != rr_last.
  - grant is registered at that edge. No data moves in the IDLE cycle, so there is 1 bubble cycle per packet.
- BUSY datapath (combinational):
  - m_axis_* = selected s*_axis_*.
  - s[grant]_tready = m_axis_tready.
  - Non-granted tready=0.
  - m_axis_tvalid=0 in IDLE.
- Beat transfer = m_axis_tvalid & m_axis_tready.
- beat_cnt (8-bit):
  - Cleared on entry to BUSY.
  - Increments on each transfer.
  - Saturates at 255.
- BUSY → IDLE:
  - On the transfer of a beat with tlast=1.
  - Same edge: rr_last ← granted index, grant ← 00, beat_cnt ← 0.
- Length error:
  - Fires on the transfer of beat number MAX_BEATS+1 without prior tlast (beat_cnt==MAX_BEATS at transfer time).
  - err_len pulses exactly once per packet.
  - Forwarding continues until tlast; no truncation.
- Keep error: err_keep pulses on any transfer with tlast=0 and tkeep != all-ones. Data is still forwarded.
- tx_enable deassertion never interrupts BUSY; it only blocks the next grant.
- Backpressure: m_axis_tready low holds the granted source. No transfer and no counter change occur.
- The arbiter never drops, duplicates or reorders beats. Packets from different sources never interleave.
- A source whose tvalid falls mid-packet (AXIS violation) simply stalls BUSY. No timeout.

Optional Feature:
- Macro: CMAC_TX_ARB_STATS_EN.
- When defined, adds outputs pkt_cnt0 and pkt_cnt1 (each 32-bit):
  - Incremented on each tlast transfer of the respective source.
  - Wrap modulo 2^32.
  - Cleared by cmac_rst.
- Also adds output err_cnt (16-bit):
  - Counts err_len|err_keep pulses; saturates at 0xFFFF.
  - Cleared by cmac_rst.
- When undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Single source: after reset, s0 sends a 4-beat packet with m_axis_tready=1.
  - Required: grant=01 one cycle after tvalid.
  - m_axis forwards 4 beats with identical data and last keep.
  - IDLE resumes; s1_tready stays 0 throughout.
- Tie round-robin: s0 and s1 both hold 3 packets of 2 beats each.
  - Required output order: s0,s1,s0,s1,s0,s1.
  - 1 idle cycle between packets; no interleaving.
- Backpressure: during a 5-beat s1 packet, m_axis_tready toggles 1,0,0,1 repeatedly.
  - Required: exactly 5 transfers, data in order.
  - s1_tready mirrors m_axis_tready.
- tx_enable: deassert during beat 2 of a 4-beat s0 packet while s1 is pending.
  - Required: s0 packet completes, then grant=00 while tx_enable=0.
  - s1 is granted one cycle after tx_enable returns to 1.
- Errors (MAX_BEATS=32):
  - 34-beat packet: err_len pulses once, on beat 33; all 34 beats forwarded.
  - Beat 1 with tkeep=0x0FFF..F and tlast=0: err_keep pulses once.
  - With CMAC_TX_ARB_STATS_EN defined: err_cnt=2 and pkt_cnt0=2 after both packets.
- Reset mid-packet: assert cmac_rst during beat 3 of an 8-beat s0 packet.
  - Required the next cycle: m_axis_tvalid=0, grant=00, s*_tready=0.
  - With both sources pending after reset release, s0 wins first.

Source files
------------

// File: rtl/cmac_tx_arbiter_if.sv
// cmac_tx_arbiter_if: 512-bit AXI-Stream bundle shared by the arbiter's two sources and its CMAC sink.
interface cmac_tx_arbiter_if #(parameter int DATA_W = 512);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;
  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/cmac_tx_arbiter.sv
// cmac_tx_arbiter: packet-atomic round-robin arbiter sharing the CMAC TX AXI-Stream between two sources.
// Define CMAC_TX_ARB_STATS_EN to add per-source packet counters and a saturating error counter.
module cmac_tx_arbiter #(
  parameter int DATA_W    = 512,
  parameter int MAX_BEATS = 32
) (
  input  logic                 cmac_tx_clk,
  input  logic                 cmac_rst,
  input  logic                 tx_enable,
  cmac_tx_arbiter_if.slave     s0_axis,
  cmac_tx_arbiter_if.slave     s1_axis,
  cmac_tx_arbiter_if.master    m_axis,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 err_len,
  output logic                 err_keep
`ifdef CMAC_TX_ARB_STATS_EN
  ,
  output logic [31:0]          pkt_cnt0,
  output logic [31:0]          pkt_cnt1,
  output logic [15:0]          err_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     r_state, w_next;
  logic [1:0] r_grant;
  logic       r_rr_last;
  logic [7:0] r_beat_cnt;
  logic       r_len_done;
  logic       w_sel, w_pick, w_start, w_xfer, w_end;
  always_ff @(posedge cmac_tx_clk)
    r_state <= cmac_rst ? IDLE : w_next;
  always_comb begin
    w_sel          = r_grant[1];
    w_pick         = (s0_axis.tvalid & s1_axis.tvalid) ? ~r_rr_last : s1_axis.tvalid;
    w_start        = (r_state == IDLE) & tx_enable & (s0_axis.tvalid | s1_axis.tvalid);
    m_axis.tdata   = w_sel ? s1_axis.tdata : s0_axis.tdata;
    m_axis.tkeep   = w_sel ? s1_axis.tkeep : s0_axis.tkeep;
    m_axis.tlast   = w_sel ? s1_axis.tlast : s0_axis.tlast;
    m_axis.tvalid  = (r_state == BUSY) & (w_sel ? s1_axis.tvalid : s0_axis.tvalid);
    s0_axis.tready = r_grant[0] & m_axis.tready;
    s1_axis.tready = r_grant[1] & m_axis.tready;
    w_xfer         = m_axis.tvalid & m_axis.tready;
    w_end          = w_xfer & m_axis.tlast;
    err_len        = w_xfer & (r_beat_cnt == 8'(MAX_BEATS)) & ~r_len_done;
    err_keep       = w_xfer & ~m_axis.tlast & ~&m_axis.tkeep;
    grant          = r_grant;
    busy           = r_state == BUSY;
    w_next         = w_start ? BUSY : w_end ? IDLE : r_state;
  end
  // r_len_done keeps err_len single-shot even when MAX_BEATS=255 pins the saturated counter
  always_ff @(posedge cmac_tx_clk) begin
    if (cmac_rst) begin
      r_grant    <= '0;
      r_rr_last  <= 1'b1;
      r_beat_cnt <= '0;
      r_len_done <= 1'b0;
    end else if (w_start) begin
      r_grant    <= w_pick ? 2'b10 : 2'b01;
      r_beat_cnt <= '0;
      r_len_done <= 1'b0;
    end else if (w_end) begin
      r_grant    <= '0;
      r_rr_last  <= w_sel;
      r_beat_cnt <= '0;
    end else if (w_xfer) begin
      if (r_beat_cnt != 8'hFF) r_beat_cnt <= r_beat_cnt + 8'd1;
      r_len_done <= r_len_done | err_len;
    end
  end
`ifdef CMAC_TX_ARB_STATS_EN
  always_ff @(posedge cmac_tx_clk) begin
    if (cmac_rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      err_cnt  <= '0;
    end else begin
      if (w_end & ~w_sel) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (w_end & w_sel) pkt_cnt1 <= pkt_cnt1 + 32'd1;
      if ((err_len | err_keep) & ~&err_cnt) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cmac_tx_arbiter.sv
// tb_cmac_tx_arbiter: randomized packet traffic on both sources, checked against a packet-level reference model.
module tb_cmac_tx_arbiter;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int MB = 32;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;
  logic clk = 1'b0;
  logic rst, tx_en;
  always #5 clk = ~clk;
  cmac_tx_arbiter_if #(.DATA_W(DW)) s0_axis ();
  cmac_tx_arbiter_if #(.DATA_W(DW)) s1_axis ();
  cmac_tx_arbiter_if #(.DATA_W(DW)) m_axis ();
  logic [1:0] grant;
  logic busy, err_len, err_keep;
`ifdef CMAC_TX_ARB_STATS_EN
  logic [31:0] pkt_cnt0, pkt_cnt1;
  logic [15:0] err_cnt;
`endif
  cmac_tx_arbiter #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
    .cmac_tx_clk(clk),
    .cmac_rst(rst),
    .tx_enable(tx_en),
    .s0_axis(s0_axis),
    .s1_axis(s1_axis),
    .m_axis(m_axis),
    .grant(grant),
    .busy(busy),
    .err_len(err_len),
    .err_keep(err_keep)
`ifdef CMAC_TX_ARB_STATS_EN
    ,
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1),
    .err_cnt(err_cnt)
`endif
  );
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  beat_t q0[$], q1[$];
  beat_t hd[2];
  bit    v[2];
  task automatic push_pkt(input int s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = rnd_data();
      b.l = (i == len - 1);
      b.k = (b.l || $urandom_range(0, 7) == 0) ? KW'({$urandom, $urandom}) : '1;
      if (s == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask
  // reference model: which source owns the link, who won last, beats sent in the current packet
  int owner, rrl, nb;
  int pkt0, pkt1, errc;
  bit mr, mv, xfer, e_len, e_keep;
  initial begin
    rst = 1'b1;
    tx_en = 1'b0;
    m_axis.tready = 1'b0;
    s0_axis.tvalid = 1'b0;
    s1_axis.tvalid = 1'b0;
    s0_axis.tdata = '0; s0_axis.tkeep = '0; s0_axis.tlast = 1'b0;
    s1_axis.tdata = '0; s1_axis.tkeep = '0; s1_axis.tlast = 1'b0;
    v[0] = 0; v[1] = 0;
    repeat (3) @(negedge clk);
    owner = -1; rrl = 1; nb = 0; pkt0 = 0; pkt1 = 0; errc = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      rst = (cyc > 50) && ($urandom_range(0, 599) == 0);
      tx_en = $urandom_range(0, 9) != 0;
      mr = $urandom_range(0, 9) < 7;
      m_axis.tready = mr;
      if (q0.size() == 0 && !v[0] && $urandom_range(0, 3) == 0)
        push_pkt(0, $urandom_range(0, 9) == 0 ? $urandom_range(30, 36) : $urandom_range(1, 6));
      if (q1.size() == 0 && !v[1] && $urandom_range(0, 3) == 0)
        push_pkt(1, $urandom_range(0, 9) == 0 ? $urandom_range(30, 36) : $urandom_range(1, 6));
      if (!v[0] && q0.size() > 0 && $urandom_range(0, 3) != 0) begin hd[0] = q0.pop_front(); v[0] = 1; end
      if (!v[1] && q1.size() > 0 && $urandom_range(0, 3) != 0) begin hd[1] = q1.pop_front(); v[1] = 1; end
      s0_axis.tvalid = v[0]; s0_axis.tdata = hd[0].d; s0_axis.tkeep = hd[0].k; s0_axis.tlast = hd[0].l;
      s1_axis.tvalid = v[1]; s1_axis.tdata = hd[1].d; s1_axis.tkeep = hd[1].k; s1_axis.tlast = hd[1].l;
      #1;
      mv = owner >= 0 && v[owner];
      xfer = mv && mr;
      e_len = xfer && nb == MB;
      e_keep = xfer && !hd[owner].l && hd[owner].k != '1;
      chk("grant", grant, owner < 0 ? 2'b00 : owner == 0 ? 2'b01 : 2'b10);
      chk("busy", busy, owner >= 0);
      chk("m_tvalid", m_axis.tvalid, mv);
      chk("s0_tready", s0_axis.tready, owner == 0 && mr);
      chk("s1_tready", s1_axis.tready, owner == 1 && mr);
      chk("err_len", err_len, e_len);
      chk("err_keep", err_keep, e_keep);
      if (mv) begin
        chk("m_tdata", m_axis.tdata, hd[owner].d);
        chk("m_tkeep", m_axis.tkeep, hd[owner].k);
        chk("m_tlast", m_axis.tlast, hd[owner].l);
      end
`ifdef CMAC_TX_ARB_STATS_EN
      chk("pkt_cnt0", pkt_cnt0, pkt0);
      chk("pkt_cnt1", pkt_cnt1, pkt1);
      chk("err_cnt", err_cnt, errc);
`endif
      if (rst) begin
        owner = -1; rrl = 1; nb = 0; pkt0 = 0; pkt1 = 0; errc = 0;
        v[0] = 0; v[1] = 0;
        q0.delete(); q1.delete();
      end else if (owner < 0) begin
        if (tx_en && (v[0] || v[1])) begin
          owner = (v[0] && v[1]) ? 1 - rrl : (v[0] ? 0 : 1);
          nb = 0;
        end
      end else if (xfer) begin
        if ((e_len || e_keep) && errc < 16'hFFFF) errc++;
        nb++;
        v[owner] = 0;
        if (hd[owner].l) begin
          if (owner == 0) pkt0++;
          else pkt1++;
          rrl = owner;
          owner = -1;
        end
      end
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
